uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte requesters. Each requester gets
//  round-robin access and may hold the line for up to MAX_BURST consecutive bytes.
//  The arbiter issues one byte at a time to the transmitter (tx_data/tx_start) and
//  waits for a complete frame, tracked on tx_busy, before it issues the next byte.
//  It sits between the producer blocks (loggers, command responders) and the UART TX.
// PARAMETERS
//  NUM_REQ       4   number of requesters, 2..8; ID_W = $clog2(NUM_REQ) (localparam)
//  MAX_BURST     4   max consecutive bytes granted to one requester before rotation, >=1
//  BUSY_TIMEOUT  8   clocks allowed after tx_start for tx_busy to rise, >=2
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst         in   1          asynchronous, active-high reset
//  req_valid   in   NUM_REQ    requester i has a byte pending
//  req_data    in   8*NUM_REQ  byte of requester i at [8*i+:8]
//  req_ack     out  NUM_REQ    1-clk pulse: byte of requester i accepted
//  tx_data     out  8          byte to transmitter, held stable until next tx_start
//  tx_start    out  1          1-clk pulse: transmitter latches tx_data
//  tx_busy     in   1          transmitter busy, high from start through end of stop bit
//  grant_id    out  ID_W       requester owning the current/last byte
//  active      out  1          high in any state other than IDLE
//  err_nobusy  out  1          1-clk pulse: tx_busy failed to rise within BUSY_TIMEOUT
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, req_ack=0, tx_start=0, tx_data=8'h00,
//   grant_id=0, err_nobusy=0, rr_ptr=NUM_REQ-1 (requester 0 wins first), burst_cnt=0, lock=0.
//  All outputs are registered.
//  FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
//  IDLE: with no req_valid, stay in IDLE. Otherwise pick winner w:
//   - if lock=1 and req_valid[grant_id], w=grant_id (burst continues);
//   - else w = first set req_valid scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ),
//     then rr_ptr<=w and burst_cnt<=0.
//   On the same edge: tx_data<=req_data[w], grant_id<=w, tx_start<=1, req_ack[w]<=1,
//   timeout count<=0, go to WAIT_BUSY. Ack and start are asserted in the same cycle,
//   one clk after the winning req_valid is sampled.
//  WAIT_BUSY: tx_start and req_ack return to 0 after one cycle. If tx_busy=1, go to
//   WAIT_DONE. Otherwise count increments; when count==BUSY_TIMEOUT-1: err_nobusy<=1
//   for one clk, lock<=0, go to IDLE. The byte is treated as consumed and not re-sent.
//  WAIT_DONE: on tx_busy=0, go to IDLE. On that edge, if burst_cnt==MAX_BURST-1 then
//   lock<=0; else lock<=1 and burst_cnt<=burst_cnt+1.
//   With MAX_BURST=1, lock is never set (pure round-robin).
//  Lock is released whenever the owner's req_valid is low in IDLE; in that case
//   normal round-robin starts from rr_ptr+1.
//  Requester rule: hold req_valid and req_data stable until req_ack. Dropping
//   req_valid before ack is legal: the request is simply not sampled.
//  Gap between frames: 1 IDLE cycle, then tx_start. Minimum 2 clks from tx_busy
//   falling to the next tx_start.
//  At most one req_ack bit is high at a time. req_ack never asserts without tx_start.
//  tx_busy high while in IDLE (e.g. after a timeout): no start is issued until it is low.
//   IDLE arbitration is gated by !tx_busy.
// TESTING
//  1 req_valid=4'b0100, data 8'hA5, tx_busy model rises 1 clk after start for 20 clks
//    -> one tx_start with tx_data=A5, req_ack=4'b0100, grant_id=2, active low after frame.
//  2 MAX_BURST=1, all four valid continuously, distinct data
//    -> grant order 0,1,2,3,0; exactly one ack per frame.
//  3 MAX_BURST=2, req1 and req3 continuously valid -> grant order 1,1,3,3,1,1.
//    Req1 valid for 1 byte only -> lock drops and req3 is granted next.
//  4 tx_busy tied 0, BUSY_TIMEOUT=8 -> err_nobusy pulse exactly 8 clks after tx_start,
//    return to IDLE, next request serviced normally.
//  5 rst asserted mid-frame (WAIT_DONE) -> all outputs at reset values in the same
//    cycle. After release, req0 wins first even if req2 was the owner.
//  6 tx_busy held high while requests pending in IDLE -> no tx_start until tx_busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART TX arbiter.
// master = arbiter side, slave = requesters/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;
  logic                 err_nobusy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ack, tx_data, tx_start, grant_id, active, err_nobusy
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ack, tx_data, tx_start, grant_id, active, err_nobusy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters,
// with bounded bursts per owner and a watchdog on the transmitter's busy response.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no byte in flight; arbitrate when tx_busy is low
// ST_WAIT_BUSY | byte issued, waiting for tx_busy to rise (with timeout)
// ST_WAIT_DONE | frame in progress, waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT);
  localparam int BST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [BST_W-1:0] BST_LAST = BST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t             state_q, state_nx;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_nx;
  logic [BST_W-1:0]   burst_q, burst_nx;
  logic               lock_q, lock_nx;
  logic [TMO_W-1:0]   tmo_q, tmo_nx;
  logic [7:0]         data_q, data_nx;
  logic [ID_W-1:0]    grant_q, grant_nx;
  logic               start_q, start_nx;
  logic [NUM_REQ-1:0] ack_q, ack_nx;
  logic               err_q, err_nx;
  logic [ID_W-1:0]    rr_win;
  logic [ID_W-1:0]    win;

  // First valid requester after rr_ptr, wrapping around.
  always_comb begin
    logic found;
    found  = 1'b0;
    rr_win = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        rr_win = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nx  = state_q;
    rr_ptr_nx = rr_ptr_q;
    burst_nx  = burst_q;
    lock_nx   = lock_q;
    tmo_nx    = tmo_q;
    data_nx   = data_q;
    grant_nx  = grant_q;
    start_nx  = 1'b0;
    ack_nx    = '0;
    err_nx    = 1'b0;
    win       = grant_q;

    case (state_q)
      ST_IDLE: begin
        if (lock_q && !bus.req_valid[grant_q])
          lock_nx = 1'b0;
        if (!bus.tx_busy && |bus.req_valid) begin
          if (lock_q && bus.req_valid[grant_q]) begin
            win = grant_q;
          end else begin
            win       = rr_win;
            rr_ptr_nx = rr_win;
            burst_nx  = '0;
          end
          data_nx     = bus.req_data[8*int'(win) +: 8];
          grant_nx    = win;
          start_nx    = 1'b1;
          ack_nx[win] = 1'b1;
          tmo_nx      = TMO_LOAD;
          state_nx    = ST_WAIT_BUSY;
        end
      end

      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nx = ST_WAIT_DONE;
        end else if (tmo_q == '0) begin
          // Byte is dropped, not retried: the requester has already been acked.
          err_nx   = 1'b1;
          lock_nx  = 1'b0;
          state_nx = ST_IDLE;
        end else begin
          tmo_nx = tmo_q - TMO_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_nx = ST_IDLE;
          if (burst_q == BST_LAST) begin
            lock_nx = 1'b0;
          end else begin
            lock_nx  = 1'b1;
            burst_nx = burst_q + BST_W'(1);
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= LAST_ID;
      burst_q  <= '0;
      lock_q   <= 1'b0;
      tmo_q    <= '0;
      data_q   <= 8'h00;
      grant_q  <= '0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nx;
      rr_ptr_q <= rr_ptr_nx;
      burst_q  <= burst_nx;
      lock_q   <= lock_nx;
      tmo_q    <= tmo_nx;
      data_q   <= data_nx;
      grant_q  <= grant_nx;
      start_q  <= start_nx;
      ack_q    <= ack_nx;
      err_q    <= err_nx;
    end
  end

  assign bus.tx_data    = data_q;
  assign bus.tx_start   = start_q;
  assign bus.req_ack    = ack_q;
  assign bus.grant_id   = grant_q;
  assign bus.err_nobusy = err_q;
  assign bus.active     = (state_q != ST_IDLE);
endmodule
